// File: rtl/mem_access_ctrl_if.sv
// Bundle of the request, data-memory bus and response channels of the
// MEM-stage access controller.
// master: the controller side (accepts requests, drives the bus and responses).
// slave:  the surrounding pipeline/bus side.
interface mem_access_ctrl_if;
    // upstream request
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [2:0]  req_load_type;
    logic [2:0]  req_store_type;
    logic [63:0] req_wdata;
    // data-memory bus
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    // response to the load extend stage
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_addr_low;
    logic [2:0]  rsp_load_type;
    logic [63:0] rsp_read_data;
    logic        rsp_err;
    logic        rsp_misalign;

    modport master (
        input  req_valid, req_addr, req_load_type, req_store_type, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        input  rsp_ready,
        output req_ready,
        output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output rsp_valid, rsp_addr_low, rsp_load_type, rsp_read_data, rsp_err, rsp_misalign
    );

    modport slave (
        output req_valid, req_addr, req_load_type, req_store_type, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        output rsp_ready,
        input  req_ready,
        input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  rsp_valid, rsp_addr_low, rsp_load_type, rsp_read_data, rsp_err, rsp_misalign
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// One outstanding load/store: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Stores get their data and byte mask shifted into the 8-byte lane here;
// loads return the raw 64-bit word plus addr_low/load_type for the extend stage.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned h/w/d
// accesses are trapped at accept (no bus request, error response with
// rsp_misalign=1); when undefined they are issued as-is and rsp_misalign stays 0.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255   // 1..255 cycles in REQ+WAIT
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_ctrl_if.master bus_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // Counter value on the last permitted cycle in REQ+WAIT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        mem_valid_q;
    logic [63:0] mem_addr_q;
    logic        mem_wen_q;
    logic [63:0] mem_wdata_q;
    logic [7:0]  mem_wmask_q;
    logic        rsp_valid_q;
    logic [2:0]  rsp_addr_low_q;
    logic [2:0]  rsp_load_type_q;
    logic [63:0] rsp_read_data_q;
    logic        rsp_err_q;
    logic        rsp_misalign_q;

    logic        is_store_d;
    logic        is_load_d;
    logic [1:0]  size_d;
    logic [7:0]  size_mask_d;
    logic [7:0]  wmask_d;
    logic [63:0] wdata_d;
    logic        misalign_d;
    logic        timeout_hit;

    // Access size code (0=b,1=h,2=w,3=d) shared by load and store encodings:
    // 100 is the doubleword, otherwise the low two bits give size+1.
    function automatic logic [1:0] size_of(input logic [2:0] t);
        if (t == 3'b100) begin
            return 2'd3;
        end
        return t[1:0] - 2'd1;
    endfunction

    // Decode the incoming request: store wins over load, byte lane alignment.
    always_comb begin
        is_store_d = (bus_if.req_store_type != 3'b000);
        is_load_d  = !is_store_d && (bus_if.req_load_type != 3'b000);
        size_d     = is_store_d ? size_of(bus_if.req_store_type)
                                : size_of(bus_if.req_load_type);
        case (size_d)
            2'd0:    size_mask_d = 8'h01;
            2'd1:    size_mask_d = 8'h03;
            2'd2:    size_mask_d = 8'h0F;
            default: size_mask_d = 8'hFF;
        endcase
        // Bytes shifted past lane 7 fall off the 8-bit mask / 64-bit word.
        wmask_d = is_store_d ? (size_mask_d << bus_if.req_addr[2:0]) : 8'h00;
        wdata_d = bus_if.req_wdata << {bus_if.req_addr[2:0], 3'b000};
`ifdef MISALIGN_TRAP_EN
        misalign_d = 1'b0;
        if (is_store_d || is_load_d) begin
            case (size_d)
                2'd1:    misalign_d = bus_if.req_addr[0];
                2'd2:    misalign_d = |bus_if.req_addr[1:0];
                2'd3:    misalign_d = |bus_if.req_addr[2:0];
                default: misalign_d = 1'b0;
            endcase
        end
`else
        misalign_d = 1'b0;
`endif
    end

    assign timeout_hit = (cnt_q == TO_LAST);

    // Transaction FSM; every bus/response output is a register set here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 8'd0;
            mem_valid_q     <= 1'b0;
            mem_addr_q      <= 64'd0;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= 64'd0;
            mem_wmask_q     <= 8'd0;
            rsp_valid_q     <= 1'b0;
            rsp_addr_low_q  <= 3'd0;
            rsp_load_type_q <= 3'd0;
            rsp_read_data_q <= 64'd0;
            rsp_err_q       <= 1'b0;
            rsp_misalign_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_if.req_valid) begin
                        cnt_q           <= 8'd0;
                        mem_addr_q      <= {bus_if.req_addr[63:3], 3'b000};
                        mem_wen_q       <= is_store_d;
                        mem_wdata_q     <= wdata_d;
                        mem_wmask_q     <= wmask_d;
                        rsp_addr_low_q  <= bus_if.req_addr[2:0];
                        rsp_load_type_q <= is_store_d ? 3'b000 : bus_if.req_load_type;
                        rsp_read_data_q <= 64'd0;
                        rsp_err_q       <= 1'b0;
                        rsp_misalign_q  <= 1'b0;
                        if (misalign_d) begin
                            // trapped: answer immediately without touching the bus
                            rsp_valid_q    <= 1'b1;
                            rsp_err_q      <= 1'b1;
                            rsp_misalign_q <= 1'b1;
                            state_q        <= RESP;
                        end else if (!is_store_d && !is_load_d) begin
                            // no-op request: empty, error-free response
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            mem_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bus_if.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= WAIT;
                    end else if (timeout_hit) begin
                        mem_valid_q <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bus_if.mem_rvalid) begin
                        rsp_read_data_q <= mem_wen_q ? 64'd0 : bus_if.mem_rdata;
                        rsp_valid_q     <= 1'b1;
                        state_q         <= RESP;
                    end else if (timeout_hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    // hold everything until downstream takes it; no accept this cycle
                    if (bus_if.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.req_ready     = (state_q == IDLE);
    assign bus_if.mem_valid     = mem_valid_q;
    assign bus_if.mem_addr      = mem_addr_q;
    assign bus_if.mem_wen       = mem_wen_q;
    assign bus_if.mem_wdata     = mem_wdata_q;
    assign bus_if.mem_wmask     = mem_wmask_q;
    assign bus_if.rsp_valid     = rsp_valid_q;
    assign bus_if.rsp_addr_low  = rsp_addr_low_q;
    assign bus_if.rsp_load_type = rsp_load_type_q;
    assign bus_if.rsp_read_data = rsp_read_data_q;
    assign bus_if.rsp_err       = rsp_err_q;
    assign bus_if.rsp_misalign  = rsp_misalign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT_CYCLES = 8).
// Expected responses are queued when a request is driven and compared
// when the controller presents rsp_valid.
module tb_mem_access_ctrl;

    logic clk;
    logic rst_n;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr_low;
        logic [2:0]  load_type;
        logic [63:0] data;
        logic        err;
        logic        misalign;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [2:0] al, input logic [2:0] lt,
                                input logic [63:0] d, input logic e, input logic m);
        exp_t r;
        r.addr_low = al; r.load_type = lt; r.data = d; r.err = e; r.misalign = m;
        return r;
    endfunction

    // Drive one request for a single accepting edge and queue its expected response.
    task automatic send_req(input logic [63:0] addr, input logic [2:0] lt, input logic [2:0] st,
                            input logic [63:0] wd, input exp_t e);
        for (int i = 0; i < 50 && bus.req_ready !== 1'b1; i++) tick();
        check_eq("req_ready_wait", bus.req_ready, 1);
        exp_q.push_back(e);
        bus.req_valid      = 1'b1;
        bus.req_addr       = addr;
        bus.req_load_type  = lt;
        bus.req_store_type = st;
        bus.req_wdata      = wd;
        tick();
        bus.req_valid      = 1'b0;
        bus.req_load_type  = 3'b000;
        bus.req_store_type = 3'b000;
        bus.req_wdata      = 64'd0;
    endtask

    // Bus model: hold mem_ready low ready_delay cycles, then rvalid after rv_gap idle cycles.
    task automatic serve_bus(input logic [63:0] ea, input logic ew, input logic [63:0] ewd,
                             input logic [7:0] em, input int ready_delay, input int rv_gap,
                             input logic [63:0] rdata);
        for (int i = 0; i <= ready_delay; i++) begin
            check_eq("mem_valid", bus.mem_valid, 1);
            check_eq("mem_addr", bus.mem_addr, ea);
            check_eq("mem_wen", bus.mem_wen, ew);
            check_eq("mem_wdata", bus.mem_wdata, ewd);
            check_eq("mem_wmask", bus.mem_wmask, em);
            if (i == ready_delay) bus.mem_ready = 1'b1;
            tick();
        end
        bus.mem_ready = 1'b0;
        check_eq("mem_valid_drop", bus.mem_valid, 0);
        repeat (rv_gap) tick();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'd0;
    endtask

    // Response sink: compare against the scoreboard, stall hold cycles, then handshake.
    task automatic take_rsp(input int hold);
        exp_t e;
        for (int i = 0; i < 50 && bus.rsp_valid !== 1'b1; i++) tick();
        check_eq("rsp_arrive", bus.rsp_valid, 1);
        check_eq("sb_nonempty", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = mk(3'd0, 3'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i <= hold; i++) begin
            check_eq("rsp_addr_low", bus.rsp_addr_low, e.addr_low);
            check_eq("rsp_load_type", bus.rsp_load_type, e.load_type);
            check_eq("rsp_read_data", bus.rsp_read_data, e.data);
            check_eq("rsp_err", bus.rsp_err, e.err);
            check_eq("rsp_misalign", bus.rsp_misalign, e.misalign);
            if (i < hold) begin
                check_eq("rsp_hold_valid", bus.rsp_valid, 1);
                check_eq("rsp_hold_req_ready", bus.req_ready, 0);
                tick();
            end
        end
        $display("rsp addr_low=%0d load_type=%b data=%h err=%b misalign=%b",
                 bus.rsp_addr_low, bus.rsp_load_type, bus.rsp_read_data,
                 bus.rsp_err, bus.rsp_misalign);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_eq("post_rsp_valid", bus.rsp_valid, 0);
        check_eq("post_rsp_idle", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_addr       = 64'd0;
        bus.req_load_type  = 3'b000;
        bus.req_store_type = 3'b000;
        bus.req_wdata      = 64'd0;
        bus.mem_ready      = 1'b0;
        bus.mem_rvalid     = 1'b0;
        bus.mem_rdata      = 64'd0;
        bus.rsp_ready      = 1'b0;
        tick();
        tick();

        // reset state
        check_eq("rst_req_ready", bus.req_ready, 1);
        check_eq("rst_mem_valid", bus.mem_valid, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_rsp_misalign", bus.rsp_misalign, 0);
        check_eq("rst_rsp_data", bus.rsp_read_data, 0);
        check_eq("rst_rsp_load_type", bus.rsp_load_type, 0);
        rst_n = 1'b1;
        tick();

        // 1: ld, zero-wait bus, response at N+3
        send_req(64'h8000_0010, 3'b100, 3'b000, 64'd0,
                 mk(3'd0, 3'b100, 64'h1122334455667788, 1'b0, 1'b0));
        serve_bus(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0, 0, 64'h1122334455667788);
        check_eq("ld_latency_n3", bus.rsp_valid, 1);
        take_rsp(0);

        // 2 + 5: sb into lane 5, response held off for 5 cycles
        send_req(64'h8000_0005, 3'b000, 3'b001, 64'h0000_0000_0000_00AB,
                 mk(3'd5, 3'b000, 64'd0, 1'b0, 1'b0));
        serve_bus(64'h8000_0000, 1'b1, 64'h0000_AB00_0000_0000, 8'h20, 0, 0, 64'hDEAD_BEEF_0BAD_F00D);
        take_rsp(5);

        // 3: lw at ...04 with a slow bus
        send_req(64'h8000_0104, 3'b011, 3'b000, 64'd0,
                 mk(3'd4, 3'b011, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0));
        serve_bus(64'h8000_0100, 1'b0, 64'd0, 8'h00, 3, 1, 64'hCAFE_F00D_1234_5678);
        take_rsp(0);

        // 4: bus never ready -> timeout after 8 REQ cycles, late rvalid dropped
        send_req(64'h8000_0208, 3'b001, 3'b000, 64'd0,
                 mk(3'd0, 3'b001, 64'd0, 1'b1, 1'b0));
        for (int i = 0; i < 8; i++) begin
            check_eq("to_mem_valid_held", bus.mem_valid, 1);
            check_eq("to_no_rsp_yet", bus.rsp_valid, 0);
            tick();
        end
        check_eq("to_mem_valid_drop", bus.mem_valid, 0);
        check_eq("to_rsp_valid", bus.rsp_valid, 1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'd0;
        take_rsp(0);
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        check_eq("idle_rvalid_ignored_rsp", bus.rsp_valid, 0);
        check_eq("idle_rvalid_ignored_rdy", bus.req_ready, 1);

        // both types 000: straight to an empty response, no bus request
        send_req(64'h8000_0301, 3'b000, 3'b000, 64'd0,
                 mk(3'd1, 3'b000, 64'd0, 1'b0, 1'b0));
        check_eq("nop_no_mem_valid", bus.mem_valid, 0);
        check_eq("nop_rsp_valid", bus.rsp_valid, 1);
        take_rsp(0);

        // both types nonzero: store wins, load type reported as 000
        send_req(64'h8000_0400, 3'b001, 3'b011, 64'h0000_0000_1122_3344,
                 mk(3'd0, 3'b000, 64'd0, 1'b0, 1'b0));
        serve_bus(64'h8000_0400, 1'b1, 64'h0000_0000_1122_3344, 8'h0F, 0, 0, 64'h5555_5555_5555_5555);
        take_rsp(0);

        // 6: sh at ...03
`ifdef MISALIGN_TRAP_EN
        send_req(64'h8000_0503, 3'b000, 3'b010, 64'h0000_0000_0000_BEEF,
                 mk(3'd3, 3'b000, 64'd0, 1'b1, 1'b1));
        check_eq("mis_no_mem_valid", bus.mem_valid, 0);
        check_eq("mis_rsp_valid", bus.rsp_valid, 1);
        take_rsp(0);
`else
        send_req(64'h8000_0503, 3'b000, 3'b010, 64'h0000_0000_0000_BEEF,
                 mk(3'd3, 3'b000, 64'd0, 1'b0, 1'b0));
        serve_bus(64'h8000_0500, 1'b1, 64'h0000_00BE_EF00_0000, 8'h18, 0, 0, 64'd0);
        take_rsp(0);
`endif

        // reset mid-WAIT abandons the transaction
        send_req(64'h8000_0600, 3'b100, 3'b000, 64'd0,
                 mk(3'd0, 3'b100, 64'd0, 1'b0, 1'b0));
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check_eq("wait_pre_req_ready", bus.req_ready, 0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req_ready", bus.req_ready, 1);
        check_eq("midrst_mem_valid", bus.mem_valid, 0);
        check_eq("midrst_rsp_valid", bus.rsp_valid, 0);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b1;
        tick();

        // recovery: a normal ld after reset
        send_req(64'h8000_0700, 3'b100, 3'b000, 64'd0,
                 mk(3'd0, 3'b100, 64'h0102_0304_0506_0708, 1'b0, 1'b0));
        serve_bus(64'h8000_0700, 1'b0, 64'd0, 8'h00, 1, 0, 64'h0102_0304_0506_0708);
        take_rsp(0);

        check_eq("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
